// File: rtl/vga_timing_param.sv
// Parametrised raster timing generator: pixel/line counters, sync, blanking,
// data enable, line/frame strobes and a wrapping frame counter.
module vga_timing_param #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 12,
    parameter int FRAME_W  = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               ce,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            CNT_W < 1 || CNT_W > 30 || FRAME_W < 1 ||
            H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_params
            $error("vga_timing_param: illegal timing parameters");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             hs_on;
    logic             vs_on;
    logic             hb_nxt;
    logic             vb_nxt;
    logic             wrap_nxt;

    // Level outputs are derived from the next position so they line up
    // with the counter values registered on the same edge.
    always_comb begin
        h_nxt = (hcount == H_LAST) ? '0 : hcount + CNT_W'(1);
        v_nxt = vcount;
        if (hcount == H_LAST) begin
            v_nxt = (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
        end
        hs_on    = (h_nxt >= HS_B) && (h_nxt <= HS_E);
        vs_on    = (v_nxt >= VS_B) && (v_nxt <= VS_E);
        hb_nxt   = (h_nxt >= H_ACT);
        vb_nxt   = (v_nxt >= V_ACT);
        wrap_nxt = (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            de          <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                hcount      <= h_nxt;
                vcount      <= v_nxt;
                hsync       <= hs_on ? HS_POL : ~HS_POL;
                vsync       <= vs_on ? VS_POL : ~VS_POL;
                hblnk       <= hb_nxt;
                vblnk       <= vb_nxt;
                de          <= ~hb_nxt & ~vb_nxt;
                line_start  <= (h_nxt == '0);
                frame_start <= wrap_nxt;
                if (wrap_nxt) begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: a default-width mode with short frames and a
// tiny negative-polarity mode, both checked against a pixel-index model.
module tb_vga_timing_param;

    localparam int AHA = 1024, AHF = 24, AHS = 136, AHB = 160;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AVA = 4, AVF = 1, AVS = 2, AVB = 1;
    localparam int AVT = AVA + AVF + AVS + AVB;
    localparam int BHA = 8, BHF = 1, BHS = 2, BHB = 1;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVA = 4, BVF = 1, BVS = 1, BVB = 1;
    localparam int BVT = BVA + BVF + BVS + BVB;

    localparam logic [46:0] A_RST = {12'd0, 12'd0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    localparam logic [16:0] B_RST = {4'd0, 4'd0, 1'b1, 1'b1,
                                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    logic [11:0] a_h, a_v;
    logic        a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs;
    logic [15:0] a_fc;
    logic [3:0]  b_h, b_v;
    logic        b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs;
    logic [1:0]  b_fc;

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing_param #(
        .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
        .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12), .FRAME_W(16)
    ) dut_a (
        .clk_in(clk), .rst(rst), .ce(ce),
        .hcount(a_h), .vcount(a_v), .hsync(a_hs), .vsync(a_vs),
        .hblnk(a_hb), .vblnk(a_vb), .de(a_de),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_param #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .FRAME_W(2)
    ) dut_b (
        .clk_in(clk), .rst(rst), .ce(ce),
        .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs),
        .hblnk(b_hb), .vblnk(b_vb), .de(b_de),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    always #5 clk = ~clk;

    // Reference: linear pixel index within the frame plus frame tally.
    int pa = 0, pb = 0, fa = 0, fb = 0;
    bit lsa = 0, fsa = 0, lsb = 0, fsb = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pa <= 0; pb <= 0; fa <= 0; fb <= 0;
            lsa <= 0; fsa <= 0; lsb <= 0; fsb <= 0;
        end else if (ce) begin
            pa  <= (pa + 1) % (AHT * AVT);
            lsa <= ((pa + 1) % AHT) == 0;
            fsa <= ((pa + 1) % (AHT * AVT)) == 0;
            if (((pa + 1) % (AHT * AVT)) == 0) fa <= fa + 1;
            pb  <= (pb + 1) % (BHT * BVT);
            lsb <= ((pb + 1) % BHT) == 0;
            fsb <= ((pb + 1) % (BHT * BVT)) == 0;
            if (((pb + 1) % (BHT * BVT)) == 0) fb <= fb + 1;
        end else begin
            lsa <= 0; fsa <= 0; lsb <= 0; fsb <= 0;
        end
    end

    function automatic logic [46:0] exp_a();
        int h, v;
        h = pa % AHT;
        v = pa / AHT;
        return {12'(h), 12'(v),
                (h >= AHA + AHF) && (h < AHA + AHF + AHS),
                (v >= AVA + AVF) && (v < AVA + AVF + AVS),
                h >= AHA, v >= AVA, (h < AHA) && (v < AVA),
                lsa, fsa, 16'(fa)};
    endfunction

    function automatic logic [16:0] exp_b();
        int h, v;
        h = pb % BHT;
        v = pb / BHT;
        return {4'(h), 4'(v),
                !((h >= BHA + BHF) && (h < BHA + BHF + BHS)),
                !((v >= BVA + BVF) && (v < BVA + BVF + BVS)),
                h >= BHA, v >= BVA, (h < BHA) && (v < BVA),
                lsb, fsb, 2'(fb)};
    endfunction

    function automatic logic [46:0] act_a();
        return {a_h, a_v, a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs, a_fc};
    endfunction

    function automatic logic [16:0] act_b();
        return {b_h, b_v, b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs, b_fc};
    endfunction

    task automatic restart();
        rst = 1'b1;
        ce  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (act_a() !== A_RST) begin
            n_bad++;
            $display("FAIL reset_a: got %h want %h", act_a(), A_RST);
        end
        n_cmp++;
        if (act_b() !== B_RST) begin
            n_bad++;
            $display("FAIL reset_b: got %h want %h", act_b(), B_RST);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_h, a_v, a_ls, a_fs} !== {12'd1, 12'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL release_a: got h=%0d v=%0d ls=%b fs=%b want 1 0 0 0",
                     a_h, a_v, a_ls, a_fs);
        end
        n_cmp++;
        if ({b_h, b_ls, b_fs} !== {4'd1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL release_b: got h=%0d ls=%b fs=%b want 1 0 0",
                     b_h, b_ls, b_fs);
        end
    endtask

    task automatic test_two_frames();
        int hs_cnt = 0, vs_cnt = 0, vb_cnt = 0, de_cnt = 0;
        int last_ls = -1;
        logic prev_hs = 1'b0;
        restart();
        for (int i = 0; i < 2 * AHT * AVT; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act_a() !== exp_a()) begin
                n_bad++;
                $display("FAIL frames_cycle %0d: got %h want %h", i, act_a(), exp_a());
            end
            if (a_hs) hs_cnt++;
            if (a_vs) vs_cnt++;
            if (a_vb) vb_cnt++;
            if (a_de) de_cnt++;
            if (a_hs && !prev_hs) begin
                n_cmp++;
                if (a_h !== 12'd1048) begin
                    n_bad++;
                    $display("FAIL hsync_start: got %0d want 1048", a_h);
                end
            end
            prev_hs = a_hs;
            if (a_ls) begin
                if (last_ls >= 0) begin
                    n_cmp++;
                    if (i - last_ls != AHT) begin
                        n_bad++;
                        $display("FAIL line_period: got %0d want %0d", i - last_ls, AHT);
                    end
                end
                last_ls = i;
            end
        end
        n_cmp++;
        if (a_fc !== 16'd2) begin
            n_bad++;
            $display("FAIL frame_cnt_end: got %0d want 2", a_fc);
        end
        n_cmp++;
        if (hs_cnt != 2 * AHS * AVT) begin
            n_bad++;
            $display("FAIL hsync_total: got %0d want %0d", hs_cnt, 2 * AHS * AVT);
        end
        n_cmp++;
        if (vs_cnt != 2 * AVS * AHT) begin
            n_bad++;
            $display("FAIL vsync_total: got %0d want %0d", vs_cnt, 2 * AVS * AHT);
        end
        n_cmp++;
        if (vb_cnt != 2 * (AVT - AVA) * AHT) begin
            n_bad++;
            $display("FAIL vblnk_total: got %0d want %0d", vb_cnt, 2 * (AVT - AVA) * AHT);
        end
        n_cmp++;
        if (de_cnt != 2 * AHA * AVA) begin
            n_bad++;
            $display("FAIL de_total: got %0d want %0d", de_cnt, 2 * AHA * AVA);
        end
    endtask

    task automatic test_boundaries();
        restart();
        repeat (AVA * AHT - 1) @(negedge clk);
        n_cmp++;
        if ({a_h, a_v, a_vb} !== {12'd1343, 12'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL pre_vblank: got h=%0d v=%0d vb=%b want 1343 3 0", a_h, a_v, a_vb);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_h, a_v, a_vb, a_de, a_ls} !== {12'd0, 12'd4, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL enter_vblank: got h=%0d v=%0d vb=%b de=%b ls=%b want 0 4 1 0 1",
                     a_h, a_v, a_vb, a_de, a_ls);
        end
        repeat (AVT * AHT - 1 - AVA * AHT) @(negedge clk);
        n_cmp++;
        if ({a_h, a_v} !== {12'd1343, 12'd7}) begin
            n_bad++;
            $display("FAIL pre_wrap: got h=%0d v=%0d want 1343 7", a_h, a_v);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_h, a_v, a_ls, a_fs, a_fc} !== {12'd0, 12'd0, 1'b1, 1'b1, 16'd1}) begin
            n_bad++;
            $display("FAIL frame_wrap: got h=%0d v=%0d ls=%b fs=%b fc=%0d want 0 0 1 1 1",
                     a_h, a_v, a_ls, a_fs, a_fc);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_h, a_ls, a_fs, a_fc} !== {12'd1, 1'b0, 1'b0, 16'd1}) begin
            n_bad++;
            $display("FAIL strobe_width: got h=%0d ls=%b fs=%b fc=%0d want 1 0 0 1",
                     a_h, a_ls, a_fs, a_fc);
        end
    endtask

    task automatic test_ce_toggle();
        int ls_cnt = 0;
        logic prev_ls = 1'b0;
        logic [11:0] prev_h = '0;
        restart();
        for (int i = 0; i < 2 * AHT; i++) begin
            ce = (i % 2 == 0);
            @(negedge clk);
            n_cmp++;
            if (act_a() !== exp_a()) begin
                n_bad++;
                $display("FAIL ce_cycle %0d: got %h want %h", i, act_a(), exp_a());
            end
            if (!ce) begin
                n_cmp++;
                if (a_h !== prev_h || a_ls !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ce_hold %0d: got h=%0d ls=%b want h=%0d ls=0",
                             i, a_h, a_ls, prev_h);
                end
            end
            if (a_ls) ls_cnt++;
            if (a_ls && prev_ls) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ls_width: got 2+ cycles want 1");
            end
            prev_ls = a_ls;
            prev_h  = a_h;
        end
        n_cmp++;
        if (ls_cnt != 1 || a_h !== 12'd0 || a_v !== 12'd1) begin
            n_bad++;
            $display("FAIL ce_line: got ls=%0d h=%0d v=%0d want 1 0 1", ls_cnt, a_h, a_v);
        end
        ce = 1'b1;
    endtask

    task automatic test_async_reset();
        restart();
        repeat (5 * AHT + 1100) @(negedge clk);
        n_cmp++;
        if ({a_h, a_v, a_hs, a_vs} !== {12'd1100, 12'd5, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL pre_reset: got h=%0d v=%0d hs=%b vs=%b want 1100 5 1 1",
                     a_h, a_v, a_hs, a_vs);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (act_a() !== A_RST) begin
            n_bad++;
            $display("FAIL async_reset_a: got %h want %h", act_a(), A_RST);
        end
        n_cmp++;
        if (act_b() !== B_RST) begin
            n_bad++;
            $display("FAIL async_reset_b: got %h want %h", act_b(), B_RST);
        end
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_h, a_v, a_ls, a_fs, a_fc} !== {12'd1, 12'd0, 1'b0, 1'b0, 16'd0}) begin
            n_bad++;
            $display("FAIL post_reset: got h=%0d v=%0d ls=%b fs=%b fc=%0d want 1 0 0 0 0",
                     a_h, a_v, a_ls, a_fs, a_fc);
        end
    endtask

    task automatic test_small_polarity();
        int frames = 0;
        int hm, vm;
        restart();
        for (int i = 0; i < 4 * BHT * BVT; i++) begin
            @(negedge clk);
            hm = pb % BHT;
            vm = pb / BHT;
            n_cmp++;
            if ({b_hs, b_vs} !== {!(hm == 9 || hm == 10), !(vm == 5)}) begin
                n_bad++;
                $display("FAIL small_sync: got hs=%b vs=%b at h=%0d v=%0d",
                         b_hs, b_vs, hm, vm);
            end
            if (b_fs) begin
                frames++;
                n_cmp++;
                if (b_fc !== 2'(frames)) begin
                    n_bad++;
                    $display("FAIL small_fcnt: got %0d want %0d", b_fc, frames % 4);
                end
            end
        end
        n_cmp++;
        if (frames != 4 || b_fc !== 2'd0) begin
            n_bad++;
            $display("FAIL small_frames: got %0d fc=%0d want 4 0", frames, b_fc);
        end
    endtask

    task automatic test_random_frames();
        int cyc = 0;
        restart();
        while (fb < 100 && cyc < 20000) begin
            ce = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (act_b() !== exp_b()) begin
                n_bad++;
                $display("FAIL rand_b %0d: got %h want %h", cyc, act_b(), exp_b());
            end
            n_cmp++;
            if (act_a() !== exp_a()) begin
                n_bad++;
                $display("FAIL rand_a %0d: got %h want %h", cyc, act_a(), exp_a());
            end
        end
        n_cmp++;
        if (fb < 100) begin
            n_bad++;
            $display("FAIL rand_timeout: got %0d frames want 100", fb);
        end
        ce = 1'b1;
    endtask

    initial begin
        test_reset();
        test_two_frames();
        test_boundaries();
        test_ce_toggle();
        test_async_reset();
        test_small_polarity();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
